// File: rtl/trace_pkg.sv
// ---------------------------------------------------------------------------
// trace_pkg -- shared types and constants for the retired-instruction trace
// monitor.
//   trace_entry_t          : one FIFO entry {instr, result}, 64 bits packed.
//   TRACE_FAIL_SIG_DEFAULT : default instruction word that marks a failed
//                            self-test.
// ---------------------------------------------------------------------------
package trace_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] result;
  } trace_entry_t;

  localparam logic [31:0] TRACE_FAIL_SIG_DEFAULT = 32'h001E6E13;

endpackage : trace_pkg

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo -- DEPTH-entry FIFO of trace entries with a registered read port.
//
// Ports
//   CLK, RST     : clock, asynchronous active-high reset
//   clr_i        : synchronous clear, beats same-cycle write and pop
//   wr_en_i      : write request, wr_data_i is the entry to store
//   rd_en_i      : pop request; the head appears on rd_data_o with
//                  rd_valid_o one cycle later
//   count_o      : occupancy, full_o / empty_o decoded from it
//
// A write while full is accepted only if a pop is accepted in the same cycle.
// A pop while empty is ignored, even if a write arrives alongside it, so a
// written entry is never bypassed straight to the read port.
// ---------------------------------------------------------------------------
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  trace_entry_t             wr_data_i,
  input  logic                     rd_en_i,
  output trace_entry_t             rd_data_o,
  output logic                     rd_valid_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_entry_t  mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  trace_entry_t  rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic          rd_fire;
  logic          wr_fire;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  assign rd_fire = rd_en_i && !empty_o && !clr_i;
  assign wr_fire = wr_en_i && (!full_o || rd_fire) && !clr_i;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    if (clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      rd_data_d = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);  // DEPTH is a power of two: wraps for free
      end
      if (rd_fire) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and count decide what is
  // valid, so stale contents are never observable.
  always_ff @(posedge CLK) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign count_o    = count_q;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule : trace_fifo

// File: rtl/trace_monitor.sv
// ---------------------------------------------------------------------------
// trace_monitor -- captures retired {instr, result} pairs into a FIFO for a
// reader, counts pairs dropped on overflow and optionally flags the first
// pair whose instruction equals the fail signature.
//
// Ports
//   CLK, RST                     : clock, asynchronous active-high reset
//   valid_i, instr_i, result_i   : retired-instruction strobe and pair
//   clr_i                        : synchronous clear of FIFO, counters, flags
//   rd_req_i                     : pop request
//   rd_data_o, rd_valid_o        : popped {instr, result}, one-cycle qualifier
//   full_o, empty_o, count_o     : FIFO status
//   overflow_o, drop_cnt_o       : sticky drop flag, saturating drop count
//   fail_o, fail_instr_o,
//   fail_result_o                : sticky fail flag and first failing pair
//
// Build option: define TRACE_FAIL_DETECT_EN to include the fail-signature
// comparator and capture registers; otherwise the fail outputs are tied to 0.
// ---------------------------------------------------------------------------
module trace_monitor
  import trace_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] FAIL_SIG = TRACE_FAIL_SIG_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   valid_i,
  input  logic [31:0]            instr_i,
  input  logic [31:0]            result_i,
  input  logic                   clr_i,
  input  logic                   rd_req_i,
  output logic [63:0]            rd_data_o,
  output logic                   rd_valid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [15:0]            drop_cnt_o,
  output logic                   fail_o,
  output logic [31:0]            fail_instr_o,
  output logic [31:0]            fail_result_o
);

  trace_entry_t wr_entry;
  trace_entry_t rd_entry;
  logic         drop;

  logic         overflow_q, overflow_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;

  assign wr_entry = '{instr: instr_i, result: result_i};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .clr_i      (clr_i),
    .wr_en_i    (valid_i),
    .wr_data_i  (wr_entry),
    .rd_en_i    (rd_req_i),
    .rd_data_o  (rd_entry),
    .rd_valid_o (rd_valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o)
  );

  assign rd_data_o = rd_entry;

  // A full FIFO is never empty, so a same-cycle pop always makes room.
  assign drop = valid_i && full_o && !rd_req_i;

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

`ifdef TRACE_FAIL_DETECT_EN
  logic        fail_q,        fail_d;
  logic [31:0] fail_instr_q,  fail_instr_d;
  logic [31:0] fail_result_q, fail_result_d;
  logic        fail_hit;

  // Detection is independent of FIFO space: a dropped failing pair still
  // counts as a failure.
  assign fail_hit = valid_i && (instr_i == FAIL_SIG);

  always_comb begin
    fail_d        = fail_q;
    fail_instr_d  = fail_instr_q;
    fail_result_d = fail_result_q;
    if (clr_i) begin
      fail_d        = 1'b0;
      fail_instr_d  = '0;
      fail_result_d = '0;
    end else if (fail_hit && !fail_q) begin
      fail_d        = 1'b1;
      fail_instr_d  = instr_i;
      fail_result_d = result_i;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fail_q        <= 1'b0;
      fail_instr_q  <= '0;
      fail_result_q <= '0;
    end else begin
      fail_q        <= fail_d;
      fail_instr_q  <= fail_instr_d;
      fail_result_q <= fail_result_d;
    end
  end

  assign fail_o        = fail_q;
  assign fail_instr_o  = fail_instr_q;
  assign fail_result_o = fail_result_q;
`else
  // FAIL_SIG stays a legal override in this build; it simply has no effect.
  logic unused_fail_sig;
  assign unused_fail_sig = ^FAIL_SIG;

  assign fail_o        = 1'b0;
  assign fail_instr_o  = '0;
  assign fail_result_o = '0;
`endif

endmodule : trace_monitor
